// File: rtl/mvu_pkg.sv
// Shared types and constants for the bit-serial matrix-vector unit.
package mvu_pkg;

    localparam int N       = 8;
    localparam int MAXPREC = 8;
    localparam int RES_W   = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACC,
        ST_OUT
    } state_t;

    // A precision of 0 is meaningless, so it behaves as 1 bit.
    function automatic logic [3:0] clamp_prec(input logic [3:0] p, input int maxp);
        if (p == 4'd0)
            return 4'd1;
        else if (int'(p) > maxp)
            return 4'(maxp);
        else
            return p;
    endfunction

endpackage

// File: rtl/mvu_popcount_mac.sv
// One bit-plane pair per call: AND, popcount, weight by 2^shamt, optional negate, accumulate.
module mvu_popcount_mac
    import mvu_pkg::*;
#(
    parameter int N = mvu_pkg::N
) (
    input  logic [N-1:0]            w_plane,
    input  logic [N-1:0]            x_plane,
    input  logic [4:0]              shamt,
    input  logic                    neg,
    input  logic signed [RES_W-1:0] acc_in,
    output logic signed [RES_W-1:0] acc_out
);

    logic [RES_W-1:0]        cnt;
    logic signed [RES_W-1:0] mag;

    always_comb begin
        cnt = '0;
        for (int j = 0; j < N; j++)
            cnt = cnt + RES_W'(w_plane[j] & x_plane[j]);
        mag     = signed'(cnt << shamt);
        acc_out = neg ? (acc_in - mag) : (acc_in + mag);
    end

endmodule

// File: rtl/mvu_top.sv
// Bit-serial GEMV engine: per row, walks all (weight plane, activation plane) pairs,
// then scales, biases and emits one 32-bit result.
module mvu_top
    import mvu_pkg::*;
#(
    parameter int N       = mvu_pkg::N,
    parameter int MAXPREC = mvu_pkg::MAXPREC
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [3:0]              wprec,
    input  logic [3:0]              iprec,
    input  logic                    wsign,
    input  logic                    isign,
    input  logic signed [15:0]      scaler,
    input  logic signed [31:0]      bias,
    input  logic                    wr_w_en,
    input  logic [5:0]              wr_w_addr,
    input  logic [N-1:0]            wr_w_data,
    input  logic                    wr_x_en,
    input  logic [2:0]              wr_x_addr,
    input  logic [N-1:0]            wr_x_data,
    output logic                    busy,
    output logic                    out_valid,
    output logic [2:0]              out_row,
    output logic signed [RES_W-1:0] out_data,
    output logic                    done
);

    logic [N-1:0] wmem [N*8];
    logic [N-1:0] xmem [8];

    state_t                  state;
    logic [2:0]              row;
    logic [3:0]              wb, ib, wp, ip;
    logic                    ws, is;
    logic signed [15:0]      scaler_q;
    logic signed [RES_W-1:0] bias_q, acc, acc_next, result;
    logic                    neg;

    assign neg    = (ws && (wb == wp - 4'd1)) ^ (is && (ib == ip - 4'd1));
    assign result = acc * RES_W'(scaler_q) + bias_q;

    mvu_popcount_mac #(.N(N)) u_mac (
        .w_plane (wmem[{row, wb[2:0]}]),
        .x_plane (xmem[ib[2:0]]),
        .shamt   (5'(wb) + 5'(ib)),
        .neg     (neg),
        .acc_in  (acc),
        .acc_out (acc_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N*8; i++) wmem[i] <= '0;
            for (int i = 0; i < 8; i++)   xmem[i] <= '0;
        end else if (!busy) begin
            if (wr_w_en) wmem[wr_w_addr] <= wr_w_data;
            if (wr_x_en) xmem[wr_x_addr] <= wr_x_data;
        end
    end

    // busy drops one cycle after the final OUT, so it stays high alongside done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            done      <= 1'b0;
            out_row   <= '0;
            out_data  <= '0;
            acc       <= '0;
            row       <= '0;
            wb        <= '0;
            ib        <= '0;
            wp        <= '0;
            ip        <= '0;
            ws        <= 1'b0;
            is        <= 1'b0;
            scaler_q  <= '0;
            bias_q    <= '0;
        end else begin
            out_valid <= 1'b0;
            done      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    busy <= 1'b0;
                    if (start) begin
                        wp       <= clamp_prec(wprec, MAXPREC);
                        ip       <= clamp_prec(iprec, MAXPREC);
                        ws       <= wsign;
                        is       <= isign;
                        scaler_q <= scaler;
                        bias_q   <= bias;
                        acc      <= '0;
                        row      <= '0;
                        wb       <= '0;
                        ib       <= '0;
                        busy     <= 1'b1;
                        state    <= ST_ACC;
                    end
                end
                ST_ACC: begin
                    acc <= acc_next;
                    if (ib == ip - 4'd1) begin
                        ib <= '0;
                        if (wb == wp - 4'd1) begin
                            wb    <= '0;
                            state <= ST_OUT;
                        end else begin
                            wb <= wb + 4'd1;
                        end
                    end else begin
                        ib <= ib + 4'd1;
                    end
                end
                ST_OUT: begin
                    out_valid <= 1'b1;
                    out_data  <= result;
                    out_row   <= row;
                    acc       <= '0;
                    if (row == 3'(N - 1)) begin
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end else begin
                        row   <= row + 3'd1;
                        state <= ST_ACC;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mvu_top.sv
// Self-checking bench for mvu_top against an integer dot-product reference model.
module tb_mvu_top;

    localparam int NN = 8;

    logic               clk, rst, start;
    logic [3:0]         wprec, iprec;
    logic               wsign, isign;
    logic signed [15:0] scaler;
    logic signed [31:0] bias;
    logic               wr_w_en, wr_x_en;
    logic [5:0]         wr_w_addr;
    logic [2:0]         wr_x_addr;
    logic [NN-1:0]      wr_w_data, wr_x_data;
    logic               busy, out_valid, done;
    logic [2:0]         out_row;
    logic signed [31:0] out_data;

    logic [7:0] wm [64];
    logic [7:0] xm [8];
    int    checks   = 0;
    int    failures = 0;
    longint cyc     = 0;

    mvu_top #(.N(NN), .MAXPREC(8)) dut (
        .clk(clk), .rst(rst), .start(start),
        .wprec(wprec), .iprec(iprec), .wsign(wsign), .isign(isign),
        .scaler(scaler), .bias(bias),
        .wr_w_en(wr_w_en), .wr_w_addr(wr_w_addr), .wr_w_data(wr_w_data),
        .wr_x_en(wr_x_en), .wr_x_addr(wr_x_addr), .wr_x_data(wr_x_data),
        .busy(busy), .out_valid(out_valid), .out_row(out_row),
        .out_data(out_data), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int clampp(input logic [3:0] p);
        if (p == 0) return 1;
        if (p > 8) return 8;
        return int'(p);
    endfunction

    // Decode each lane to an integer and form the true dot product.
    function automatic logic [31:0] model_row(input int r, input int wp, input int ip,
                                              input bit ws, input bit is,
                                              input longint sc, input longint bs);
        longint dot, res, wv, xv;
        dot = 0;
        for (int j = 0; j < NN; j++) begin
            wv = 0;
            xv = 0;
            for (int b = 0; b < wp; b++) if (wm[r*8+b][j]) wv += (longint'(1) << b);
            for (int b = 0; b < ip; b++) if (xm[b][j])     xv += (longint'(1) << b);
            if (ws && wv >= (longint'(1) << (wp-1))) wv -= (longint'(1) << wp);
            if (is && xv >= (longint'(1) << (ip-1))) xv -= (longint'(1) << ip);
            dot += wv * xv;
        end
        res = dot * sc + bs;
        return res[31:0];
    endfunction

    task automatic wr_w(input int a, input logic [7:0] d);
        wr_w_en = 1'b1; wr_w_addr = 6'(a); wr_w_data = d;
        @(negedge clk);
        wr_w_en = 1'b0;
        wm[a] = d;
    endtask

    task automatic wr_x(input int a, input logic [7:0] d);
        wr_x_en = 1'b1; wr_x_addr = 3'(a); wr_x_data = d;
        @(negedge clk);
        wr_x_en = 1'b0;
        xm[a] = d;
    endtask

    task automatic fill_all(input logic [7:0] w, input logic [7:0] x);
        for (int a = 0; a < 64; a++) wr_w(a, w);
        for (int a = 0; a < 8; a++)  wr_x(a, x);
    endtask

    task automatic fill_rand();
        for (int a = 0; a < 64; a++) wr_w(a, 8'($urandom));
        for (int a = 0; a < 8; a++)  wr_x(a, 8'($urandom));
    endtask

    // Entered and left on a falling edge so jobs can be issued back to back.
    task automatic run_job(input logic [3:0] wpr, input logic [3:0] ipr,
                           input logic wsg, input logic isg,
                           input logic [15:0] sc, input logic [31:0] bs,
                           input int abort_row, input bit disturb);
        int wpc, ipc, p, seen, bad;
        bit aborted;
        longint c_s;
        logic [31:0] expv [8];
        wpc = clampp(wpr);
        ipc = clampp(ipr);
        p = wpc * ipc;
        seen = 0;
        aborted = 1'b0;
        for (int r = 0; r < 8; r++)
            expv[r] = model_row(r, wpc, ipc, wsg, isg, longint'($signed(sc)), longint'($signed(bs)));
        wprec = wpr; iprec = ipr; wsign = wsg; isign = isg; scaler = sc; bias = bs;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c_s = cyc;
        for (int k = 0; k < 8*(p+1) + 10 && seen < 8 && !aborted; k++) begin
            @(negedge clk);
            start = 1'b0;
            wr_w_en = 1'b0;
            if (out_valid) begin
                chk("row", 32'(out_row), 32'(seen));
                chk("data", out_data, expv[seen]);
                chk("latency", 32'(cyc - c_s), 32'((seen+1)*(p+1)));
                chk("done", 32'(done), 32'(seen == 7));
                seen++;
                if (seen - 1 == abort_row) begin
                    rst = 1'b1;
                    #1;
                    chk("rst_busy", 32'(busy), 0);
                    chk("rst_valid", 32'(out_valid), 0);
                    aborted = 1'b1;
                end
            end else begin
                chk("stray_done", 32'(done), 0);
            end
            if (disturb && k == 2) begin
                start = 1'b1;
                wr_w_en = 1'b1; wr_w_addr = 6'd0; wr_w_data = ~wm[0];
            end
        end
        if (aborted) begin
            @(negedge clk);
            rst = 1'b0;
            bad = 0;
            for (int k = 0; k < 8*(p+1) + 5; k++) begin
                @(negedge clk);
                if (out_valid || done) bad++;
            end
            chk("post_rst_quiet", 32'(bad), 0);
            for (int a = 0; a < 64; a++) wm[a] = '0;
            for (int a = 0; a < 8; a++)  xm[a] = '0;
        end else begin
            chk("rows_seen", 32'(seen), 8);
            @(negedge clk);
            chk("busy_fall", 32'(busy), 0);
            chk("hold_data", out_data, expv[7]);
            chk("hold_row", 32'(out_row), 7);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; wprec = '0; iprec = '0; wsign = 1'b0; isign = 1'b0;
        scaler = '0; bias = '0; wr_w_en = 1'b0; wr_x_en = 1'b0;
        wr_w_addr = '0; wr_x_addr = '0; wr_w_data = '0; wr_x_data = '0;
        for (int a = 0; a < 64; a++) wm[a] = '0;
        for (int a = 0; a < 8; a++)  xm[a] = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy0", 32'(busy), 0);
        chk("rst_valid0", 32'(out_valid), 0);
        chk("rst_done0", 32'(done), 0);
        chk("rst_row0", 32'(out_row), 0);
        chk("rst_data0", out_data, 0);
        rst = 1'b0;
        @(negedge clk);

        fill_all(8'hFF, 8'hFF);
        run_job(4'd1, 4'd1, 1'b0, 1'b0, 16'sd1, 32'sd0, -1, 1'b0);
        run_job(4'd1, 4'd1, 1'b0, 1'b0, 16'sd3, -32'sd5, -1, 1'b0);
        run_job(4'd1, 4'd1, 1'b0, 1'b0, 16'sd1, 32'sd0, -1, 1'b1);
        run_job(4'd0, 4'd12, 1'b0, 1'b0, 16'sd1, 32'sd0, -1, 1'b0);

        for (int r = 0; r < 8; r++) begin
            wr_w(r*8, 8'hFF);
            wr_w(r*8 + 1, 8'h00);
        end
        wr_x(0, 8'hFF);
        wr_x(1, 8'hFF);
        run_job(4'd2, 4'd2, 1'b1, 1'b1, 16'sd1, 32'sd0, -1, 1'b0);

        for (int t = 0; t < 6; t++) begin
            fill_rand();
            run_job(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    1'($urandom), 1'($urandom), 16'($urandom), 32'($urandom), -1, 1'b0);
        end

        fill_rand();
        run_job(4'd3, 4'd2, 1'b1, 1'b0, 16'sd7, 32'sd100, 2, 1'b0);
        run_job(4'd4, 4'd4, 1'b1, 1'b1, 16'($urandom), 32'($urandom), -1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mvu_top.md
MVU_TOP -- requirements
Module: mvu_top

Interface
REQ-001 Parameter N, default 8, meaning vector length = matrix rows = matrix columns (lanes).
REQ-002 Parameter MAXPREC, default 8, meaning maximum bit precision of weights and activations.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port start  input  1  one-cycle request to begin a GEMV job.
REQ-006 Port wprec, iprec  input  4 each  weight / activation precision in bits.
REQ-007 Port wsign, isign  input  1 each  1 = two's-complement operand, 0 = unsigned.
REQ-008 Port scaler  input  16  signed post-accumulation multiplier.
REQ-009 Port bias  input  32  signed scalar bias added to every output.
REQ-010 Port wr_w_en, wr_w_addr[5:0], wr_w_data[N-1:0]  input  weight bit-plane write; addr = row*8 + plane.
REQ-011 Port wr_x_en, wr_x_addr[2:0], wr_x_data[N-1:0]  input  activation bit-plane write; addr = plane; bit j = element j.
REQ-012 Port busy  output  1  job in progress.
REQ-013 Port out_valid  output  1  one-cycle strobe qualifying out_row/out_data.
REQ-014 Port out_row  output  3  row index of current result.
REQ-015 Port out_data  output  32  signed result for out_row.
REQ-016 Port done  output  1  one-cycle pulse coincident with the last row's out_valid.

Function
REQ-017 Weight memory (N*8 words of N bits) and activation memory (8 words of N bits) shall be register arrays, written on the clock edge when the enable is high and busy is low; writes while busy shall be ignored.
REQ-018 start sampled while idle shall latch wprec, iprec, wsign, isign, scaler and bias, set busy next cycle and clear the accumulator; start while busy shall be ignored.
REQ-019 Precision 0 shall be treated as 1; values above MAXPREC shall be clamped to MAXPREC. P = wprec*iprec after clamping.
REQ-020 States: IDLE -> ACC (P cycles per row) -> OUT (1 cycle) -> ACC for the next row, or -> IDLE after row N-1.
REQ-021 In ACC, one (wb, ib) pair per cycle, ib inner loop, wb outer: term = popcount(W[r][wb] AND X[ib]) << (wb+ib), negated when (wsign and wb==wprec-1) XOR (isign and ib==iprec-1); acc += term (signed, 32-bit).
REQ-022 In OUT: out_data = (acc * scaler + bias) truncated to 32 bits two's-complement wrap, out_row = r, out_valid = 1; acc cleared for the next row.
REQ-023 out_valid for row r shall be asserted (r+1)*(P+1) cycles after the start edge; rows emitted in order 0..N-1; job length N*(P+1) cycles.
REQ-024 done shall pulse in the same cycle as row N-1's out_valid; busy shall fall the following cycle, and start shall be accepted in that first idle cycle.
REQ-025 Outside OUT, out_valid and done shall be 0; out_data and out_row shall hold their last values.

Reset
REQ-026 rst shall asynchronously force IDLE, busy=0, out_valid=0, done=0, out_row=0, out_data=0, acc=0, counters=0; memories shall be cleared to 0.
REQ-027 Reset mid-job shall abort it; no further out_valid or done for that job after release.

Structure
REQ-028 N, MAXPREC, the state enum and the result width (32) shall be in a shared package mvu_pkg.
REQ-029 One sub-module, mvu_popcount_mac (AND, popcount, shift, conditional negate, accumulate), shall be instantiated by mvu_top.

Verification
REQ-030 1-bit unsigned, all W and X planes 0xFF, scaler 1, bias 0 -> eight out_valid, every 2 cycles, each out_data = 8; done with row 7.
REQ-031 2-bit signed, X planes 0xFF/0xFF (x=-1), W planes 0xFF/0x00 (w=1) -> every row out_data = -8 (0xFFFFFFF8), out_valid every 5 cycles.
REQ-032 Same as REQ-030 with scaler 3, bias -5 -> every out_data = 19.
REQ-033 start pulsed again while busy, and wr_w_en while busy -> ignored; results unchanged from single-job run.
REQ-034 rst asserted after row 2 output -> busy=0, out_valid=0 immediately; no further outputs; memories read back as zero results (out_data = bias) on next job.
REQ-035 wprec=0, iprec=12 unsigned -> treated as 1 and 8: P=8, out_valid every 9 cycles.
